// File: rtl/noc_memory_responder_pkg.sv
// Shared NOC types for the memory responder slice: packet layout, packet kinds,
// port status and the node location of the memory responder.
package noc_memory_responder_pkg;

    typedef enum logic [3:0] {
        pkt_none             = 4'd0,
        memory_read_request  = 4'd1,
        memory_write_request = 4'd2,
        memory_read_reply    = 4'd3,
        memory_write_reply   = 4'd4
    } packet_type;

    typedef enum logic {
        port_closed = 1'b0,
        port_open   = 1'b1
    } port_status;

    typedef struct packed {
        logic [7:0]   dst_addr;
        logic [3:0]   dst_prt;
        logic [7:0]   src_addr;
        logic [3:0]   src_prt;
        logic [7:0]   id;
        packet_type   pt;
        logic [127:0] dat;
    } packet;

    // Where initiators must send memory requests
    localparam logic [7:0] NOC_MEM_NODE_ADDR = 8'd2;
    localparam logic [3:0] NOC_MEM_NODE_PRT  = 4'd0;

endpackage

// File: rtl/ip_port.sv
// Endpoint side of a NOC port: one receive channel and one transmit channel.
interface ip_port;
    import noc_memory_responder_pkg::*;

    packet      dat_from_noc;
    logic       rx_recieve;
    logic       rx_complete;
    packet      dat_to_noc;
    logic       tx_submit;
    logic       tx_complete;
    port_status to_noc_prt_stat;
    logic [7:0] port_address;
    logic [3:0] port_number;

    modport responder (
        input  dat_from_noc,
        input  rx_recieve,
        output rx_complete,
        output dat_to_noc,
        output tx_submit,
        input  tx_complete,
        input  to_noc_prt_stat,
        input  port_address,
        input  port_number
    );

endinterface

// File: rtl/noc_memory_responder_word_ram.sv
// Single-port word RAM: synchronous write, combinational read, never cleared.
module word_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Store the word on the clock edge when the responder commits a write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/noc_memory_responder.sv
// NOC memory endpoint: takes one read/write request at a time, accesses the
// word RAM and returns the matching reply to the requester.
module noc_memory_responder
    import noc_memory_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ip_port.responder   noc_port,
    output logic        busy,
    output logic [31:0] served_count
);

    localparam int          ADDR_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, CONSUME, EXEC, REPLY} responder_state;

    responder_state    state, state_next;
    packet             req_pkt, reply_pkt, reply_next;
    logic [31:0]       req_addr, byte_offset, ram_rdata;
    logic [ADDR_W-1:0] word_idx;
    logic              in_range, is_read, is_write, ram_we, reply_accepted;
    logic              rx_complete_c, tx_submit_c;
    logic              unused_req_bits;

    // Addresses below BASE_ADDR wrap to huge offsets and so fall out of range
    assign req_addr       = req_pkt.dat[31:0];
    assign byte_offset    = req_addr - BASE_ADDR;
    assign in_range       = byte_offset < SPAN_BYTES;
    assign word_idx       = byte_offset[ADDR_W+1:2];
    assign is_read        = req_pkt.pt == memory_read_request;
    assign is_write       = req_pkt.pt == memory_write_request;
    assign reply_accepted = (state == REPLY) && (noc_port.to_noc_prt_stat == port_open)
                            && noc_port.tx_complete;
    assign ram_we         = (state == EXEC) && is_write && in_range && !rst;
    assign unused_req_bits = ^{req_pkt.dst_addr, req_pkt.dst_prt, req_pkt.dat[127:64]};

    word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (req_pkt.dat[63:32]),
        .rdata (ram_rdata)
    );

    // State register; reset abandons whatever transaction is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake strobes; unknown packet types go straight back to IDLE
    always_comb begin
        state_next    = state;
        rx_complete_c = 1'b0;
        tx_submit_c   = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (noc_port.rx_recieve) begin
                    state_next = CONSUME;
                end
            end
            CONSUME: begin
                rx_complete_c = 1'b1;
                state_next    = (is_read || is_write) ? EXEC : IDLE;
            end
            EXEC: begin
                state_next = REPLY;
            end
            REPLY: begin
                tx_submit_c = 1'b1;
                if (reply_accepted) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reply packet routed back to the requester; reads return RAM data, writes echo the address
    always_comb begin
        reply_next          = '0;
        reply_next.dst_addr = req_pkt.src_addr;
        reply_next.dst_prt  = req_pkt.src_prt;
        reply_next.src_addr = noc_port.port_address;
        reply_next.src_prt  = noc_port.port_number;
        reply_next.id       = req_pkt.id;
        if (is_read) begin
            reply_next.pt        = memory_read_reply;
            reply_next.dat[31:0] = in_range ? ram_rdata : 32'h0;
        end else begin
            reply_next.pt        = memory_write_reply;
            reply_next.dat[31:0] = req_addr;
        end
    end

    // Capture the incoming request while idle; the NOC holds it until rx_complete
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && noc_port.rx_recieve) begin
            req_pkt <= noc_port.dat_from_noc;
        end
    end

    // Reply register and delivered-reply counter
    always_ff @(posedge clk) begin
        if (rst) begin
            reply_pkt    <= '0;
            served_count <= 32'd0;
        end else begin
            if (state == EXEC) begin
                reply_pkt <= reply_next;
            end
            if (reply_accepted) begin
                served_count <= served_count + 32'd1;
            end
        end
    end

    assign noc_port.rx_complete = rx_complete_c;
    assign noc_port.tx_submit   = tx_submit_c;
    assign noc_port.dat_to_noc  = reply_pkt;

endmodule

// File: tb/tb_noc_memory_responder.sv
// Directed bench for noc_memory_responder: acts as the NOC around the endpoint.
module tb_noc_memory_responder;
    import noc_memory_responder_pkg::*;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [31:0] served_count;
    int          checkCount;
    int          passCount;
    int          failCount;
    int          expServed;

    ip_port noc_if();

    noc_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .noc_port     (noc_if),
        .busy         (busy),
        .served_count (served_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [191:0] observed,
                               input logic [191:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a request packet to the responder
    task automatic applyStimulus(input packet_type pt, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [7:0] sa,
                                 input logic [3:0] sp, input logic [7:0] id);
        packet p;
        p          = '0;
        p.dst_addr = NOC_MEM_NODE_ADDR;
        p.dst_prt  = NOC_MEM_NODE_PRT;
        p.src_addr = sa;
        p.src_prt  = sp;
        p.id       = id;
        p.pt       = pt;
        p.dat      = {64'h0, data, addr};
        noc_if.dat_from_noc = p;
        noc_if.rx_recieve   = 1'b1;
    endtask

    function automatic packet expReply(input packet_type pt, input logic [31:0] d,
                                       input logic [7:0] da, input logic [3:0] dp,
                                       input logic [7:0] id);
        packet p;
        p          = '0;
        p.dst_addr = da;
        p.dst_prt  = dp;
        p.src_addr = 8'd2;
        p.src_prt  = 4'd0;
        p.id       = id;
        p.pt       = pt;
        p.dat      = {96'h0, d};
        return p;
    endfunction

    // Watch one transaction from request to return-to-idle, bounded at 20 cycles
    task automatic collectReply(output packet reply, output int rxPulses,
                                output int latency, output bit gotReply,
                                output int overlap);
        bit done;
        reply    = '0;
        rxPulses = 0;
        latency  = 0;
        gotReply = 1'b0;
        overlap  = 0;
        done     = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (noc_if.rx_complete && noc_if.tx_submit) overlap++;
            if (noc_if.rx_complete) begin
                rxPulses++;
                noc_if.rx_recieve = 1'b0;
            end
            if (noc_if.tx_submit && !gotReply) begin
                gotReply = 1'b1;
                latency  = c;
                reply    = noc_if.dat_to_noc;
            end
            if (c > 1 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("txn_completes", 192'(done), 192'(1));
    endtask

    task automatic doTxn(input packet_type pt, input logic [31:0] addr,
                         input logic [31:0] data, input logic [7:0] sa,
                         input logic [3:0] sp, input logic [7:0] id,
                         output packet reply, output int rxPulses, output int latency,
                         output bit gotReply);
        int overlap;
        applyStimulus(pt, addr, data, sa, sp, id);
        collectReply(reply, rxPulses, latency, gotReply, overlap);
        checkOutput("rx_tx_overlap", 192'(overlap), 192'(0));
    endtask

    initial begin
        packet rep;
        packet held;
        int    rxp;
        int    lat;
        bit    got;
        int    ovl;
        int    unstable;

        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        expServed  = 0;
        rst = 1'b1;
        noc_if.dat_from_noc    = '0;
        noc_if.rx_recieve      = 1'b0;
        noc_if.tx_complete     = 1'b1;
        noc_if.to_noc_prt_stat = port_open;
        noc_if.port_address    = NOC_MEM_NODE_ADDR;
        noc_if.port_number     = NOC_MEM_NODE_PRT;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_busy", 192'(busy), 192'(0));
        checkOutput("rst_tx_submit", 192'(noc_if.tx_submit), 192'(0));
        checkOutput("rst_rx_complete", 192'(noc_if.rx_complete), 192'(0));
        checkOutput("rst_served", 192'(served_count), 192'(0));
        checkOutput("rst_dat_to_noc", 192'(noc_if.dat_to_noc), 192'(0));
        rst = 1'b0;

        $display("[TB] write then read");
        doTxn(memory_write_request, 32'h100, 32'hDEAD_BEEF, 8'd1, 4'd3, 8'd5, rep, rxp, lat, got);
        expServed++;
        checkOutput("wr_reply", 192'(rep), 192'(expReply(memory_write_reply, 32'h100, 8'd1, 4'd3, 8'd5)));
        doTxn(memory_read_request, 32'h100, 32'h0, 8'd1, 4'd3, 8'd6, rep, rxp, lat, got);
        expServed++;
        checkOutput("rd_reply", 192'(rep), 192'(expReply(memory_read_reply, 32'hDEAD_BEEF, 8'd1, 4'd3, 8'd6)));
        checkOutput("served_2", 192'(served_count), 192'(expServed));

        $display("[TB] stack push/pop");
        doTxn(memory_write_request, 32'h3FC, 32'h40, 8'd4, 4'd1, 8'd7, rep, rxp, lat, got);
        expServed++;
        checkOutput("push_rx_pulses", 192'(rxp), 192'(1));
        checkOutput("push_latency", 192'(lat), 192'(3));
        doTxn(memory_read_request, 32'h3FC, 32'h0, 8'd4, 4'd1, 8'd8, rep, rxp, lat, got);
        expServed++;
        checkOutput("pop_reply", 192'(rep), 192'(expReply(memory_read_reply, 32'h40, 8'd4, 4'd1, 8'd8)));
        checkOutput("pop_rx_pulses", 192'(rxp), 192'(1));
        checkOutput("pop_latency", 192'(lat), 192'(3));

        $display("[TB] back-pressure");
        noc_if.to_noc_prt_stat = port_closed;
        noc_if.tx_complete     = 1'b0;
        applyStimulus(memory_read_request, 32'h100, 32'h0, 8'd9, 4'd2, 8'd10);
        held = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (noc_if.rx_complete) noc_if.rx_recieve = 1'b0;
            if (c == 3) held = noc_if.dat_to_noc;
        end
        checkOutput("bp_tx_submit", 192'(noc_if.tx_submit), 192'(1));
        checkOutput("bp_held_reply", 192'(held), 192'(expReply(memory_read_reply, 32'hDEAD_BEEF, 8'd9, 4'd2, 8'd10)));
        applyStimulus(memory_read_request, 32'h3FC, 32'h0, 8'd9, 4'd2, 8'd11);
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (noc_if.tx_submit !== 1'b1 || noc_if.dat_to_noc !== held ||
                noc_if.rx_complete !== 1'b0 || served_count !== 32'(expServed))
                unstable++;
        end
        checkOutput("bp_stable", 192'(unstable), 192'(0));
        noc_if.to_noc_prt_stat = port_open;
        noc_if.tx_complete     = 1'b1;
        @(negedge clk);
        expServed++;
        checkOutput("bp_served", 192'(served_count), 192'(expServed));
        checkOutput("bp_idle", 192'(busy), 192'(0));
        collectReply(rep, rxp, lat, got, ovl);
        expServed++;
        checkOutput("bp_second_reply", 192'(rep), 192'(expReply(memory_read_reply, 32'h40, 8'd9, 4'd2, 8'd11)));
        checkOutput("bp_second_latency", 192'(lat), 192'(3));

        $display("[TB] out of range");
        doTxn(memory_write_request, 32'h0, 32'h1111_1111, 8'd1, 4'd0, 8'd20, rep, rxp, lat, got);
        doTxn(memory_write_request, 32'hFFC, 32'h1234_5678, 8'd1, 4'd0, 8'd21, rep, rxp, lat, got);
        doTxn(memory_read_request, 32'h1000, 32'h0, 8'd1, 4'd0, 8'd22, rep, rxp, lat, got);
        checkOutput("oor_read_zero", 192'(rep), 192'(expReply(memory_read_reply, 32'h0, 8'd1, 4'd0, 8'd22)));
        doTxn(memory_write_request, 32'h1000, 32'hBADC_0DE1, 8'd1, 4'd0, 8'd23, rep, rxp, lat, got);
        checkOutput("oor_write_echo", 192'(rep), 192'(expReply(memory_write_reply, 32'h1000, 8'd1, 4'd0, 8'd23)));
        doTxn(memory_read_request, 32'hFFC, 32'h0, 8'd1, 4'd0, 8'd24, rep, rxp, lat, got);
        checkOutput("last_word_kept", 192'(rep.dat[31:0]), 192'(32'h1234_5678));
        doTxn(memory_read_request, 32'h0, 32'h0, 8'd1, 4'd0, 8'd25, rep, rxp, lat, got);
        checkOutput("word0_kept", 192'(rep.dat[31:0]), 192'(32'h1111_1111));
        doTxn(memory_read_request, 32'h103, 32'h0, 8'd1, 4'd0, 8'd26, rep, rxp, lat, got);
        checkOutput("low_bits_ignored", 192'(rep.dat[31:0]), 192'(32'hDEAD_BEEF));
        expServed += 7;
        checkOutput("served_after_oor", 192'(served_count), 192'(expServed));

        $display("[TB] unknown packet type");
        doTxn(memory_read_reply, 32'h100, 32'h0, 8'd1, 4'd0, 8'd30, rep, rxp, lat, got);
        checkOutput("unk_rx_pulses", 192'(rxp), 192'(1));
        checkOutput("unk_no_reply", 192'(got), 192'(0));
        checkOutput("unk_served", 192'(served_count), 192'(expServed));

        $display("[TB] reset mid-reply");
        noc_if.to_noc_prt_stat = port_closed;
        noc_if.tx_complete     = 1'b0;
        applyStimulus(memory_read_request, 32'h3FC, 32'h0, 8'd1, 4'd0, 8'd40);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (noc_if.rx_complete) noc_if.rx_recieve = 1'b0;
        end
        checkOutput("mid_tx_submit", 192'(noc_if.tx_submit), 192'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_tx_submit", 192'(noc_if.tx_submit), 192'(0));
        checkOutput("mid_rst_busy", 192'(busy), 192'(0));
        checkOutput("mid_rst_served", 192'(served_count), 192'(0));
        noc_if.to_noc_prt_stat = port_open;
        noc_if.tx_complete     = 1'b1;
        doTxn(memory_read_request, 32'h100, 32'h0, 8'd1, 4'd3, 8'd41, rep, rxp, lat, got);
        checkOutput("ram_kept_after_rst", 192'(rep), 192'(expReply(memory_read_reply, 32'hDEAD_BEEF, 8'd1, 4'd3, 8'd41)));
        checkOutput("served_after_rst", 192'(served_count), 192'(1));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
